// File: rtl/picorv32_mem_arbiter.sv
// Two-port to one-port arbiter for the picorv32 native memory bus (CPU + vector coprocessor).
// One transaction in flight at a time; grant held until mem_ready or a timeout forces completion.
module picorv32_mem_arbiter #(
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    input  logic        vec_mem_valid,
    input  logic [31:0] vec_mem_addr,
    input  logic [31:0] vec_mem_wdata,
    input  logic [3:0]  vec_mem_wstrb,
    output logic        vec_mem_ready,
    output logic [31:0] vec_mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        grant_vec,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_CPU,
        S_BUSY_VEC
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_vec;
    logic [31:0] r_cnt;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_vec_rdata;
    logic        w_pick_vec;
    logic        w_busy;
    logic        w_tout;
    logic        w_done;
    logic [31:0] w_rsp;

    always_comb begin
        w_pick_vec = 1'b0;
        if (vec_mem_valid && !cpu_mem_valid) begin
            w_pick_vec = 1'b1;
        end else if (vec_mem_valid && cpu_mem_valid) begin
            if (ARB_MODE == 1)      w_pick_vec = 1'b0;
            else if (ARB_MODE == 2) w_pick_vec = 1'b1;
            else                    w_pick_vec = !r_last_vec;
        end
    end

    // A real mem_ready in the timeout cycle takes precedence: data is forwarded, no error.
    assign w_busy = (r_state != S_IDLE);
    assign w_tout = w_busy && (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);
    assign w_done = w_busy && (mem_ready || w_tout);
    assign w_rsp  = mem_ready ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_mem_valid || vec_mem_valid)
                    w_next = w_pick_vec ? S_BUSY_VEC : S_BUSY_CPU;
            end
            S_BUSY_CPU, S_BUSY_VEC: begin
                if (w_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_mem_ready = !reset && (r_state == S_BUSY_CPU) && w_done;
        vec_mem_ready = !reset && (r_state == S_BUSY_VEC) && w_done;
        cpu_mem_rdata = cpu_mem_ready ? w_rsp : r_cpu_rdata;
        vec_mem_rdata = vec_mem_ready ? w_rsp : r_vec_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            mem_instr   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            grant_vec   <= 1'b0;
            timeout_err <= 1'b0;
            r_last_vec  <= 1'b1;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_vec_rdata <= '0;
        end else begin
            if (cpu_mem_ready) r_cpu_rdata <= w_rsp;
            if (vec_mem_ready) r_vec_rdata <= w_rsp;
            if (r_state == S_IDLE) begin
                if (w_next != S_IDLE) begin
                    mem_valid <= 1'b1;
                    mem_instr <= !w_pick_vec && cpu_mem_instr;
                    mem_addr  <= w_pick_vec ? vec_mem_addr  : cpu_mem_addr;
                    mem_wdata <= w_pick_vec ? vec_mem_wdata : cpu_mem_wdata;
                    mem_wstrb <= w_pick_vec ? vec_mem_wstrb : cpu_mem_wstrb;
                    grant_vec <= w_pick_vec;
                    r_cnt     <= '0;
                end
            end else if (w_done) begin
                mem_valid  <= 1'b0;
                mem_wstrb  <= '0;
                r_last_vec <= (r_state == S_BUSY_VEC);
                if (!mem_ready) timeout_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter: round-robin instance with a short timeout
// plus a CPU-priority instance sharing the same requesters.
module tb_picorv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mem_valid = 1'b0, cpu_mem_instr = 1'b0;
    logic [31:0] cpu_mem_addr = '0, cpu_mem_wdata = '0;
    logic [3:0]  cpu_mem_wstrb = '0;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        vec_mem_valid = 1'b0;
    logic [31:0] vec_mem_addr = '0, vec_mem_wdata = '0;
    logic [3:0]  vec_mem_wstrb = '0;
    logic        vec_mem_ready;
    logic [31:0] vec_mem_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        grant_vec, timeout_err;

    logic        p_cpu_ready, p_vec_ready, p_mem_valid, p_mem_instr, p_grant_vec, p_timeout_err;
    logic [31:0] p_cpu_rdata, p_vec_rdata, p_mem_addr, p_mem_wdata;
    logic [3:0]  p_mem_wstrb;
    logic        p_mem_ready = 1'b0;
    logic [31:0] p_mem_rdata = '0;

    logic [31:0] mem [0:1023];
    bit          mem_auto = 1'b1;
    bit          man_ready = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
        .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_vec(grant_vec), .timeout_err(timeout_err)
    );

    picorv32_mem_arbiter #(.ARB_MODE(1)) dut_p (
        .clk(clk), .reset(reset),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(p_cpu_ready), .cpu_mem_rdata(p_cpu_rdata),
        .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(p_vec_ready), .vec_mem_rdata(p_vec_rdata),
        .mem_valid(p_mem_valid), .mem_instr(p_mem_instr), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_wstrb(p_mem_wstrb),
        .mem_ready(p_mem_ready), .mem_rdata(p_mem_rdata),
        .grant_vec(p_grant_vec), .timeout_err(p_timeout_err)
    );

    // One-cycle memory; man_ready forces a response when the auto responder is off.
    always @(posedge clk) begin
        if ((mem_auto && mem_valid && !mem_ready) || man_ready) begin
            mem_ready <= 1'b1;
            mem_rdata <= mem[mem_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
            mem_ready <= 1'b0;
        end
    end

    always @(posedge clk) p_mem_ready <= p_mem_valid && !p_mem_ready;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({mem_valid, mem_instr, mem_wstrb, grant_vec, timeout_err} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000000", {mem_valid, mem_instr, mem_wstrb, grant_vec, timeout_err});
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h want 0", {mem_addr, mem_wdata});
        end
        n_tests++;
        if ({cpu_mem_ready, vec_mem_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", {cpu_mem_ready, vec_mem_ready});
        end
        n_tests++;
        if ({cpu_mem_rdata, vec_mem_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", {cpu_mem_rdata, vec_mem_rdata});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lone_cpu();
        cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b1; cpu_mem_addr = 32'd0; cpu_mem_wstrb = 4'h0;
        n_tests++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL lone_n_valid: got %b want 0", mem_valid); end
        tick();
        n_tests++;
        if ({mem_valid, mem_instr, cpu_mem_ready} !== 3'b110 || mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL lone_n1: got valid/instr/rdy %b addr %h want 110 addr 0", {mem_valid, mem_instr, cpu_mem_ready}, mem_addr);
        end
        tick();
        n_tests++;
        if ({cpu_mem_ready, vec_mem_ready, grant_vec} !== 3'b100) begin
            n_fail++; $display("FAIL lone_n2_ready: got %b want 100", {cpu_mem_ready, vec_mem_ready, grant_vec});
        end
        n_tests++;
        if (cpu_mem_rdata !== 32'h00100113) begin
            n_fail++; $display("FAIL lone_rdata: got %h want 00100113", cpu_mem_rdata);
        end
        cpu_mem_valid = 1'b0;
        tick();
        n_tests++;
        if ({mem_valid, cpu_mem_ready} !== 2'b00) begin
            n_fail++; $display("FAIL lone_idle: got %b want 00", {mem_valid, cpu_mem_ready});
        end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1; tick(); reset = 1'b0;
        cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b1; cpu_mem_addr = 32'd400; cpu_mem_wstrb = 4'h0;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd800; vec_mem_wdata = 32'hA5A5A5A5; vec_mem_wstrb = 4'hF;
        tick();
        n_tests++;
        if (grant_vec !== 1'b0 || mem_addr !== 32'd400 || mem_instr !== 1'b1) begin
            n_fail++; $display("FAIL simul_first_grant: got gv %b addr %0d instr %b want 0 400 1", grant_vec, mem_addr, mem_instr);
        end
        tick();
        n_tests++;
        if ({cpu_mem_ready, vec_mem_ready} !== 2'b10 || cpu_mem_rdata !== 32'hBEEF0000) begin
            n_fail++; $display("FAIL simul_cpu_done: got rdy %b rdata %h want 10 BEEF0000", {cpu_mem_ready, vec_mem_ready}, cpu_mem_rdata);
        end
        cpu_mem_valid = 1'b0;
        tick();
        n_tests++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL simul_gap: got %b want 0", mem_valid); end
        tick();
        n_tests++;
        if (grant_vec !== 1'b1 || mem_addr !== 32'd800 || mem_wdata !== 32'hA5A5A5A5 || mem_wstrb !== 4'hF || mem_instr !== 1'b0) begin
            n_fail++; $display("FAIL simul_vec_grant: got gv %b addr %0d wd %h ws %h instr %b want 1 800 A5A5A5A5 f 0",
                               grant_vec, mem_addr, mem_wdata, mem_wstrb, mem_instr);
        end
        tick();
        n_tests++;
        if ({cpu_mem_ready, vec_mem_ready} !== 2'b01) begin
            n_fail++; $display("FAIL simul_vec_done: got %b want 01", {cpu_mem_ready, vec_mem_ready});
        end
        vec_mem_valid = 1'b0;
        tick();
        n_tests++;
        if ({mem_valid, mem_wstrb, grant_vec} !== 6'b000001) begin
            n_fail++; $display("FAIL simul_after: got %b want 000001", {mem_valid, mem_wstrb, grant_vec});
        end
        n_tests++;
        if (mem[200] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL simul_write: got %h want A5A5A5A5", mem[200]); end
    endtask

    task automatic test_contention();
        int done = 0;
        int last_cyc = 0;
        int p_cpu = 0;
        int p_vec = 0;
        bit exp_vec = 1'b0;
        tick(); tick();
        cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b0; cpu_mem_addr = 32'd400; cpu_mem_wstrb = 4'h0;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd404; vec_mem_wstrb = 4'h0;
        for (int cyc = 1; cyc <= 40 && done < 6; cyc++) begin
            tick();
            if (p_cpu_ready) p_cpu++;
            if (p_vec_ready) p_vec++;
            if (cpu_mem_ready || vec_mem_ready) begin
                n_tests++;
                if ({cpu_mem_ready, vec_mem_ready, grant_vec} !== {!exp_vec, exp_vec, exp_vec}) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", done, {cpu_mem_ready, vec_mem_ready, grant_vec}, {!exp_vec, exp_vec, exp_vec});
                end
                n_tests++;
                if ((exp_vec ? vec_mem_rdata : cpu_mem_rdata) !== (exp_vec ? 32'hBEEF0001 : 32'hBEEF0000)) begin
                    n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", done, exp_vec ? vec_mem_rdata : cpu_mem_rdata, exp_vec ? 32'hBEEF0001 : 32'hBEEF0000);
                end
                n_tests++;
                if (cyc - last_cyc !== (done == 0 ? 2 : 3)) begin
                    n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", done, cyc - last_cyc, done == 0 ? 2 : 3);
                end
                last_cyc = cyc;
                exp_vec = !exp_vec;
                done++;
            end
        end
        cpu_mem_valid = 1'b0; vec_mem_valid = 1'b0;
        n_tests++;
        if (done !== 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", done); end
        n_tests++;
        if (p_cpu !== 6 || p_vec !== 0) begin
            n_fail++; $display("FAIL prio_cpu: got cpu %0d vec %0d want 6 0", p_cpu, p_vec);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_strided();
        int k = 0;
        int ncpu = 0;
        int bad = 0;
        cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b1; cpu_mem_addr = 32'd0;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd400; vec_mem_wstrb = 4'h0;
        for (int cyc = 0; cyc < 200 && k < 16; cyc++) begin
            tick();
            if ((cpu_mem_ready && grant_vec) || (cpu_mem_ready && vec_mem_ready)) bad++;
            if (cpu_mem_ready) begin
                n_tests++;
                if (cpu_mem_rdata !== 32'h00100113) begin
                    n_fail++; $display("FAIL stride_cpu_rdata: got %h want 00100113", cpu_mem_rdata);
                end
                ncpu++;
            end
            if (vec_mem_ready) begin
                n_tests++;
                if (vec_mem_rdata !== (32'hBEEF0000 | 32'(k))) begin
                    n_fail++; $display("FAIL stride_vec_rdata[%0d]: got %h want %h", k, vec_mem_rdata, 32'hBEEF0000 | 32'(k));
                end
                k++;
                vec_mem_addr = 32'd400 + 32'(4 * k);
                if (k == 16) begin vec_mem_valid = 1'b0; cpu_mem_valid = 1'b0; end
            end
        end
        vec_mem_valid = 1'b0; cpu_mem_valid = 1'b0;
        n_tests++;
        if (k !== 16 || ncpu !== 16 || bad !== 0) begin
            n_fail++; $display("FAIL stride_summary: got vec %0d cpu %0d bad %0d want 16 16 0", k, ncpu, bad);
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        mem_auto = 1'b0;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd408; vec_mem_wstrb = 4'h0;
        tick(); tick(); tick();
        man_ready = 1'b1;
        tick();
        n_tests++;
        if (vec_mem_ready !== 1'b1 || vec_mem_rdata !== 32'hBEEF0002) begin
            n_fail++; $display("FAIL tout_race: got rdy %b rdata %h want 1 BEEF0002", vec_mem_ready, vec_mem_rdata);
        end
        man_ready = 1'b0; vec_mem_valid = 1'b0;
        tick();
        n_tests++;
        if ({timeout_err, mem_valid} !== 2'b00) begin n_fail++; $display("FAIL tout_race_err: got %b want 00", {timeout_err, mem_valid}); end

        cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b0; cpu_mem_addr = 32'd12;
        tick();
        cpu_mem_addr = 32'd99;
        tick();
        n_tests++;
        if (mem_addr !== 32'd12 || mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL tout_hold: got addr %0d valid %b want 12 1", mem_addr, mem_valid);
        end
        tick();
        n_tests++;
        if (cpu_mem_ready !== 1'b0) begin n_fail++; $display("FAIL tout_early: got %b want 0", cpu_mem_ready); end
        tick();
        n_tests++;
        if ({cpu_mem_ready, vec_mem_ready, timeout_err} !== 3'b100 || cpu_mem_rdata !== 32'h0) begin
            n_fail++; $display("FAIL tout_fire: got %b rdata %h want 100 0", {cpu_mem_ready, vec_mem_ready, timeout_err}, cpu_mem_rdata);
        end
        cpu_mem_valid = 1'b0;
        tick();
        n_tests++;
        if ({timeout_err, mem_valid, cpu_mem_ready} !== 3'b100 || mem_wstrb !== 4'h0) begin
            n_fail++; $display("FAIL tout_err: got %b ws %h want 100 0", {timeout_err, mem_valid, cpu_mem_ready}, mem_wstrb);
        end

        mem_auto = 1'b1;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd404;
        tick(); tick();
        n_tests++;
        if (vec_mem_ready !== 1'b1 || vec_mem_rdata !== 32'hBEEF0001) begin
            n_fail++; $display("FAIL tout_recover: got %b %h want 1 BEEF0001", vec_mem_ready, vec_mem_rdata);
        end
        vec_mem_valid = 1'b0;
        tick();
        n_tests++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tout_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0;
        vec_mem_valid = 1'b1; vec_mem_addr = 32'd404;
        tick();
        n_tests++;
        if ({mem_valid, grant_vec} !== 2'b11) begin n_fail++; $display("FAIL rmid_busy: got %b want 11", {mem_valid, grant_vec}); end
        tick();
        reset = 1'b1; man_ready = 1'b1;
        tick();
        n_tests++;
        if ({mem_valid, grant_vec, timeout_err, cpu_mem_ready, vec_mem_ready} !== 5'b00000) begin
            n_fail++; $display("FAIL rmid_reset: got %b want 00000", {mem_valid, grant_vec, timeout_err, cpu_mem_ready, vec_mem_ready});
        end
        reset = 1'b0; man_ready = 1'b0; vec_mem_valid = 1'b0;
        #1;
        n_tests++;
        if ({mem_ready, cpu_mem_ready, vec_mem_ready} !== 3'b100) begin
            n_fail++; $display("FAIL rmid_late_ready: got %b want 100", {mem_ready, cpu_mem_ready, vec_mem_ready});
        end
        tick();
        n_tests++;
        if ({mem_valid, cpu_mem_ready, vec_mem_ready} !== 3'b000) begin
            n_fail++; $display("FAIL rmid_after: got %b want 000", {mem_valid, cpu_mem_ready, vec_mem_ready});
        end
        mem_auto = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h00100113;
        for (int k = 0; k < 16; k++) mem[100 + k] = 32'hBEEF0000 | 32'(k);
        test_reset();
        test_lone_cpu();
        test_simultaneous();
        test_contention();
        test_strided();
        test_timeout();
        test_reset_mid();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
